// File: rtl/cnt_pkg.sv
// Shared definitions for the counter family: mode encodings and load clamp.
// Used by cnt_updown_mod and future multi-channel counter banks.
package cnt_pkg;

  localparam int CNT_MODE_WRAP = 0;
  localparam int CNT_MODE_SAT  = 1;

  function automatic int unsigned clamp_load(
    input int unsigned d,
    input int unsigned max
  );
    return (d > max - 1) ? max - 1 : d;
  endfunction

endpackage

// File: rtl/cnt_end_detect.sv
// Range-end detector: flags when the next step in direction up crosses an end.
// Shared by terminal-count and next-state logic.
module cnt_end_detect #(
  parameter int M   = 8,
  parameter int MAX = 256
) (
  input  logic [M-1:0] q,
  input  logic         up,
  output logic         at_top,
  output logic         at_bot
);

  localparam int unsigned TOP = MAX - 1;
  localparam logic [M-1:0] TOP_V = TOP[M-1:0];

  assign at_top = up & (q == TOP_V);
  assign at_bot = ~up & (q == '0);

endmodule

// File: rtl/cnt_updown_mod.sv
// Modulo-MAX up/down counter with load, wrap/saturate mode,
// terminal-count strobe for cascading and sticky overflow flag.
module cnt_updown_mod
  import cnt_pkg::*;
#(
  parameter int M   = 8,
  parameter int MAX = 256,
  parameter int SAT = CNT_MODE_WRAP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         up,
  input  logic         ld,
  input  logic [M-1:0] d,
  input  logic         clr_ovf,
  output logic [M-1:0] q,
  output logic         tc,
  output logic         ovf
);

  localparam int unsigned TOP = MAX - 1;
  localparam logic [M-1:0] TOP_V = TOP[M-1:0];
  localparam bit SAT_MODE = (SAT == CNT_MODE_SAT);

  logic         at_top;
  logic         at_bot;
  logic [M-1:0] q_nxt;
  logic         ovf_nxt;

  cnt_end_detect #(
    .M   (M),
    .MAX (MAX)
  ) u_end (
    .q      (q),
    .up     (up),
    .at_top (at_top),
    .at_bot (at_bot)
  );

  assign tc = ce & ~ld & (at_top | at_bot);

  always_comb begin
    q_nxt   = q;
    ovf_nxt = ovf;
    if (ld) begin
      q_nxt = M'(clamp_load(32'(d), MAX));
    end else if (ce) begin
      if (up) begin
        if (at_top) q_nxt = SAT_MODE ? q : '0;
        else        q_nxt = q + M'(1);
      end else begin
        if (at_bot) q_nxt = SAT_MODE ? q : TOP_V;
        else        q_nxt = q - M'(1);
      end
    end
    // set beats clear when both land on the same edge
    if (tc)           ovf_nxt = 1'b1;
    else if (clr_ovf) ovf_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      q   <= q_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_cnt_updown_mod.sv
// Directed bench: wrap instance, saturate instance and a two-stage cascade,
// all M=4, MAX=10, with hand-computed expected values.
module tb_cnt_updown_mod;
  import cnt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // wrap instance
  logic       w_ce = 0, w_up = 0, w_ld = 0, w_clr = 0;
  logic [3:0] w_d = '0, w_q;
  logic       w_tc, w_ovf;

  cnt_updown_mod #(.M(4), .MAX(10), .SAT(CNT_MODE_WRAP)) u_wrap (
    .clk(clk), .rst(rst), .ce(w_ce), .up(w_up), .ld(w_ld), .d(w_d),
    .clr_ovf(w_clr), .q(w_q), .tc(w_tc), .ovf(w_ovf)
  );

  // saturate instance
  logic       s_ce = 0, s_up = 0, s_ld = 0, s_clr = 0;
  logic [3:0] s_d = '0, s_q;
  logic       s_tc, s_ovf;

  cnt_updown_mod #(.M(4), .MAX(10), .SAT(CNT_MODE_SAT)) u_sat (
    .clk(clk), .rst(rst), .ce(s_ce), .up(s_up), .ld(s_ld), .d(s_d),
    .clr_ovf(s_clr), .q(s_q), .tc(s_tc), .ovf(s_ovf)
  );

  // cascade: stage 1 counts on stage 0 terminal count
  logic       c_ce = 0;
  logic [3:0] c0_q, c1_q;
  logic       c0_tc, c0_ovf, c1_tc, c1_ovf;

  cnt_updown_mod #(.M(4), .MAX(10), .SAT(CNT_MODE_WRAP)) u_c0 (
    .clk(clk), .rst(rst), .ce(c_ce), .up(1'b1), .ld(1'b0), .d(4'd0),
    .clr_ovf(1'b0), .q(c0_q), .tc(c0_tc), .ovf(c0_ovf)
  );

  cnt_updown_mod #(.M(4), .MAX(10), .SAT(CNT_MODE_WRAP)) u_c1 (
    .clk(clk), .rst(rst), .ce(c0_tc), .up(1'b1), .ld(1'b0), .d(4'd0),
    .clr_ovf(1'b0), .q(c1_q), .tc(c1_tc), .ovf(c1_ovf)
  );

  initial begin
    // reset state
    tick();
    chk("rst_q", w_q, 0);
    chk("rst_ovf", w_ovf, 0);
    rst = 0;

    // reset mid-count
    w_ld = 1; w_d = 4'd7;
    tick();
    chk("ld7", w_q, 7);
    w_ld = 0; w_ce = 1; w_up = 1; rst = 1;
    tick();
    chk("rst_mid_q", w_q, 0);
    chk("rst_mid_ovf", w_ovf, 0);
    tick();
    chk("rst_ce_q", w_q, 0);
    rst = 0;

    // wrap up-count 0..9,0
    for (int i = 0; i < 10; i++) begin
      chk("up_q", w_q, i);
      chk("up_tc", w_tc, (i == 9) ? 1 : 0);
      chk("up_ovf", w_ovf, 0);
      tick();
    end
    chk("wrap_q", w_q, 0);
    chk("wrap_ovf", w_ovf, 1);

    // down from 0, clear collides with tc
    w_ce = 0; w_clr = 1;
    tick();
    chk("clr_ovf", w_ovf, 0);
    w_ce = 1; w_up = 0; w_clr = 1;
    #1;
    chk("dn_tc0", w_tc, 1);
    tick();
    chk("dn_q9", w_q, 9);
    chk("set_wins", w_ovf, 1);
    w_clr = 0;
    chk("dn_tc9", w_tc, 0);
    tick();
    chk("dn_q8", w_q, 8);
    w_clr = 1;
    tick();
    chk("clr_q8_ovf", w_ovf, 0);
    chk("dn_q7", w_q, 7);
    w_clr = 0;

    // load priority and clamp
    w_ld = 1; w_ce = 1; w_up = 1; w_d = 4'd5;
    tick();
    chk("ld5", w_q, 5);
    w_d = 4'd13;
    tick();
    chk("ld13_clamp", w_q, 9);
    w_d = 4'd9;
    #1;
    chk("ld_tc", w_tc, 0);
    tick();
    chk("ld_ovf", w_ovf, 0);
    chk("ld9", w_q, 9);
    w_ld = 0; w_ce = 0;

    // saturate mode
    s_ld = 1; s_d = 4'd8;
    tick();
    s_ld = 0; s_ce = 1; s_up = 1;
    chk("sat_q8", s_q, 8);
    chk("sat_tc8", s_tc, 0);
    tick();
    chk("sat_q9a", s_q, 9);
    chk("sat_tc9", s_tc, 1);
    tick();
    chk("sat_q9b", s_q, 9);
    chk("sat_tc9b", s_tc, 1);
    chk("sat_ovf", s_ovf, 1);
    tick();
    chk("sat_q9c", s_q, 9);
    s_up = 0;
    tick();
    chk("sat_dn8", s_q, 8);
    tick();
    chk("sat_dn7", s_q, 7);
    s_ce = 0;

    // saturate at bottom holds
    s_ld = 1; s_d = 4'd0;
    tick();
    s_ld = 0; s_ce = 1; s_up = 0;
    tick();
    chk("sat_bot", s_q, 0);
    s_ce = 0;

    // cascade
    c_ce = 1;
    repeat (37) tick();
    chk("cas37_lo", c0_q, 7);
    chk("cas37_hi", c1_q, 3);
    repeat (63) tick();
    c_ce = 0;
    chk("cas100_lo", c0_q, 0);
    chk("cas100_hi", c1_q, 0);
    chk("cas_ovf1", c1_ovf, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
